gemm_tile_ctrl: RTL and testbench

Sequencer for the output-stationary GEMM array built from `general_mac_pe` instances. It walks an M×N grid of output tiles and, for each one, steps through K reduction steps. It drives the operand SRAM read addresses and the PE control strobes (`a_valid`, `b_valid`, `init_save`, `acc_clr`), then hands each finished result to the writeback path with a valid/ready handshake. It sits between the top-level job control (`start`/`done`) and the PE array plus operand/result memories.

---
 rtl/gemm_tile_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_gemm_tile_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl
// ----------------------------------------------------------------------------
// Sequencer for an output-stationary GEMM array of general_mac_pe instances.
// It walks an M x N grid of output tiles in row-major order. For each tile it
// steps through K reduction steps, drives the A/B operand SRAM read addresses
// and the PE control strobes, then offers the finished result to the
// writeback path with a valid/ready handshake.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   start_i      : job start, honoured only while idle
//   m_size_i     : output rows (tiles), latched at start
//   k_size_i     : reduction steps, latched at start
//   n_size_i     : output columns (tiles), latched at start
//   a_addr_o     : A SRAM read address (m*K + k), zero outside LOAD
//   b_addr_o     : B SRAM read address (k*N + n), zero outside LOAD
//   a_valid_o    : PE a_valid (LOAD delayed one cycle for SRAM latency)
//   b_valid_o    : PE b_valid (same timing as a_valid_o)
//   init_save_o  : PE init_save, marks reduction step 0
//   acc_clr_o    : PE acc_clr, pulsed in the DONE cycle
//   c_valid_o    : result available for writeback
//   c_addr_o     : C write address (m*N + n), zero outside WRITE
//   c_ready_i    : writeback accepts the result
//   busy_o       : high in every state except IDLE
//   done_o       : one-cycle pulse at job end
// ----------------------------------------------------------------------------
module gemm_tile_ctrl #(
    parameter int AddrWidth = 16,
    parameter int SizeWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [SizeWidth-1:0] m_size_i,
    input  logic [SizeWidth-1:0] k_size_i,
    input  logic [SizeWidth-1:0] n_size_i,
    output logic [AddrWidth-1:0] a_addr_o,
    output logic [AddrWidth-1:0] b_addr_o,
    output logic                 a_valid_o,
    output logic                 b_valid_o,
    output logic                 init_save_o,
    output logic                 acc_clr_o,
    output logic                 c_valid_o,
    output logic [AddrWidth-1:0] c_addr_o,
    input  logic                 c_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam logic [SizeWidth-1:0] SizeOne = SizeWidth'(1);
    localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);

    state_e                 state_q, state_d;
    logic [SizeWidth-1:0]   m_size_q, m_size_d;
    logic [SizeWidth-1:0]   k_size_q, k_size_d;
    logic [SizeWidth-1:0]   n_size_q, n_size_d;
    logic [SizeWidth-1:0]   m_cnt_q, m_cnt_d;
    logic [SizeWidth-1:0]   n_cnt_q, n_cnt_d;
    logic [SizeWidth-1:0]   k_cnt_q, k_cnt_d;
    // a_base tracks m*K, a_ptr tracks m*K + k, b_ptr tracks k*N + n and
    // c_ptr tracks m*N + n, which is simply the tile index in row-major order.
    logic [AddrWidth-1:0]   a_base_q, a_base_d;
    logic [AddrWidth-1:0]   a_ptr_q, a_ptr_d;
    logic [AddrWidth-1:0]   b_ptr_q, b_ptr_d;
    logic [AddrWidth-1:0]   c_ptr_q, c_ptr_d;
    logic                   op_valid_q, op_valid_d;
    logic                   init_save_q, init_save_d;

    logic                   k_last;
    logic                   n_last;
    logic                   m_last;
    logic                   any_zero;
    logic [AddrWidth-1:0]   k_ext;
    logic [AddrWidth-1:0]   n_ext;
    logic [AddrWidth-1:0]   n_size_ext;

    assign k_last     = (k_cnt_q == k_size_q - SizeOne);
    assign n_last     = (n_cnt_q == n_size_q - SizeOne);
    assign m_last     = (m_cnt_q == m_size_q - SizeOne);
    assign any_zero   = (m_size_i == '0) || (k_size_i == '0) || (n_size_i == '0);
    assign k_ext      = AddrWidth'(k_size_q);
    assign n_ext      = AddrWidth'(n_cnt_q);
    assign n_size_ext = AddrWidth'(n_size_q);

    // State and datapath registers. Reset drops any in-flight operand valid
    // so the PE sees no strobe in the cycle after reset, even mid-job.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            m_size_q    <= '0;
            k_size_q    <= '0;
            n_size_q    <= '0;
            m_cnt_q     <= '0;
            n_cnt_q     <= '0;
            k_cnt_q     <= '0;
            a_base_q    <= '0;
            a_ptr_q     <= '0;
            b_ptr_q     <= '0;
            c_ptr_q     <= '0;
            op_valid_q  <= 1'b0;
            init_save_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_size_q    <= m_size_d;
            k_size_q    <= k_size_d;
            n_size_q    <= n_size_d;
            m_cnt_q     <= m_cnt_d;
            n_cnt_q     <= n_cnt_d;
            k_cnt_q     <= k_cnt_d;
            a_base_q    <= a_base_d;
            a_ptr_q     <= a_ptr_d;
            b_ptr_q     <= b_ptr_d;
            c_ptr_q     <= c_ptr_d;
            op_valid_q  <= op_valid_d;
            init_save_q <= init_save_d;
        end
    end

    // Next-state and counter logic. Addresses advance with running adds
    // (+1 for A, +N for B) so no multiplier is needed. The operand valid and
    // init_save are delayed copies of "in LOAD" and "in LOAD at k==0", which
    // lines them up with the data coming back from the 1-cycle SRAMs.
    always_comb begin
        state_d     = state_q;
        m_size_d    = m_size_q;
        k_size_d    = k_size_q;
        n_size_d    = n_size_q;
        m_cnt_d     = m_cnt_q;
        n_cnt_d     = n_cnt_q;
        k_cnt_d     = k_cnt_q;
        a_base_d    = a_base_q;
        a_ptr_d     = a_ptr_q;
        b_ptr_d     = b_ptr_q;
        c_ptr_d     = c_ptr_q;
        op_valid_d  = (state_q == ST_LOAD);
        init_save_d = (state_q == ST_LOAD) && (k_cnt_q == '0);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    m_size_d = m_size_i;
                    k_size_d = k_size_i;
                    n_size_d = n_size_i;
                    m_cnt_d  = '0;
                    n_cnt_d  = '0;
                    k_cnt_d  = '0;
                    a_base_d = '0;
                    a_ptr_d  = '0;
                    b_ptr_d  = '0;
                    c_ptr_d  = '0;
                    state_d  = any_zero ? ST_DONE : ST_LOAD;
                end
            end

            ST_LOAD: begin
                a_ptr_d = a_ptr_q + AddrOne;
                b_ptr_d = b_ptr_q + n_size_ext;
                if (k_last) begin
                    k_cnt_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_cnt_d = k_cnt_q + SizeOne;
                end
            end

            ST_DRAIN: begin
                state_d = ST_WRITE;
            end

            ST_WRITE: begin
                if (c_ready_i) begin
                    c_ptr_d = c_ptr_q + AddrOne;
                    if (n_last) begin
                        n_cnt_d = '0;
                        if (m_last) begin
                            state_d = ST_DONE;
                        end else begin
                            m_cnt_d  = m_cnt_q + SizeOne;
                            a_base_d = a_base_q + k_ext;
                            a_ptr_d  = a_base_q + k_ext;
                            b_ptr_d  = '0;
                            state_d  = ST_LOAD;
                        end
                    end else begin
                        n_cnt_d = n_cnt_q + SizeOne;
                        a_ptr_d = a_base_q;
                        b_ptr_d = n_ext + AddrOne;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Addresses are forced to zero outside the states that own them so the
    // memories see a quiet bus while idle or stalled.
    assign a_addr_o    = (state_q == ST_LOAD)  ? a_ptr_q : '0;
    assign b_addr_o    = (state_q == ST_LOAD)  ? b_ptr_q : '0;
    assign c_addr_o    = (state_q == ST_WRITE) ? c_ptr_q : '0;
    assign a_valid_o   = op_valid_q;
    assign b_valid_o   = op_valid_q;
    assign init_save_o = init_save_q;
    assign c_valid_o   = (state_q == ST_WRITE);
    assign done_o      = (state_q == ST_DONE);
    assign acc_clr_o   = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// tb_gemm_tile_ctrl
// ----------------------------------------------------------------------------
// Scoreboard testbench for gemm_tile_ctrl. Stimulus tasks push the expected
// operand strobes, writeback addresses and done cycle into queues; an
// independent monitor pops and compares whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_gemm_tile_ctrl;

   typedef struct {
      int cyc;
      int a;
      int b;
      int init;
   } op_t;

   typedef struct {
      int cyc;
      int addr;
   } wr_t;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  m_size_i;
   logic [7:0]  k_size_i;
   logic [7:0]  n_size_i;
   logic [15:0] a_addr_o;
   logic [15:0] b_addr_o;
   logic        a_valid_o;
   logic        b_valid_o;
   logic        init_save_o;
   logic        acc_clr_o;
   logic        c_valid_o;
   logic [15:0] c_addr_o;
   logic        c_ready_i;
   logic        busy_o;
   logic        done_o;

   int cyc = 0;
   int startCyc = 0;
   int asserts = 0;
   int failures = 0;
   int stallLen = 0;
   int stallCnt = 0;

   op_t opQ[$];
   wr_t cQ[$];
   int  doneQ[$];

   gemm_tile_ctrl #(.AddrWidth(16), .SizeWidth(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .m_size_i    (m_size_i),
      .k_size_i    (k_size_i),
      .n_size_i    (n_size_i),
      .a_addr_o    (a_addr_o),
      .b_addr_o    (b_addr_o),
      .a_valid_o   (a_valid_o),
      .b_valid_o   (b_valid_o),
      .init_save_o (init_save_o),
      .acc_clr_o   (acc_clr_o),
      .c_valid_o   (c_valid_o),
      .c_addr_o    (c_addr_o),
      .c_ready_i   (c_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   // Free-running clock plus a cycle counter that the stimulus uses to
   // timestamp the start-accept cycle and the monitor uses to check timing.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: every check in the bench funnels through here.
   task automatic checkOutput(input string name, input int actual, input int expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Writeback model: holds ready low for the first stallLen cycles of every
   // WRITE, then accepts. With stallLen = 0 ready is simply held high.
   initial begin
      c_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (c_valid_o === 1'b1 && stallCnt < stallLen) begin
            c_ready_i = 1'b0;
            stallCnt++;
         end else begin
            c_ready_i = 1'b1;
            if (c_valid_o !== 1'b1) stallCnt = 0;
         end
      end
   end

   // Reference model of the job: tile t of an M x N x K job with S stall
   // cycles per WRITE opens at cycle 1 + t*(K+2+S). Operand pairs appear one
   // cycle after their address, the result is taken S cycles after c_valid
   // rises, and done lands one cycle after the last tile window.
   task automatic pushJob(input int m, input int n, input int k, input int s);
      int tileLen;
      int t0;
      tileLen = k + 2 + s;
      if (m == 0 || n == 0 || k == 0) begin
         doneQ.push_back(startCyc + 1);
      end else begin
         for (int t = 0; t < m * n; t++) begin
            t0 = startCyc + 1 + t * tileLen;
            for (int j = 0; j < k; j++)
               opQ.push_back('{t0 + 1 + j, (t / n) * k + j, j * n + (t % n), (j == 0) ? 1 : 0});
            cQ.push_back('{t0 + k + 1 + s, t});
         end
         doneQ.push_back(startCyc + 1 + m * n * tileLen);
      end
   endtask

   task automatic gotoCycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issues one start pulse (cycle 0 = start accepted) and optionally loads
   // the scoreboard with the full expected response of the job.
   task automatic applyStimulus(input int m, input int n, input int k, input int s, input bit push);
      stallLen = s;
      @(posedge clk);
      #1;
      m_size_i = 8'(m);
      n_size_i = 8'(n);
      k_size_i = 8'(k);
      start_i  = 1'b1;
      startCyc = cyc;
      if (push) pushJob(m, n, k, s);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
      checkOutput("busy_at_cycle1", int'(busy_o), 1);
   endtask

   task automatic waitDone(input string name);
      int budget;
      budget = 0;
      while (doneQ.size() != 0 && budget < 1000) begin
         @(posedge clk);
         budget++;
      end
      if (doneQ.size() != 0) begin
         checkOutput({name, "_done_timeout"}, doneQ.size(), 0);
         doneQ.delete();
      end
      repeat (2) @(posedge clk);
      checkOutput({name, "_ops_left"}, opQ.size(), 0);
      checkOutput({name, "_writes_left"}, cQ.size(), 0);
      opQ.delete();
      cQ.delete();
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_a_addr"}, int'(a_addr_o), 0);
      checkOutput({name, "_b_addr"}, int'(b_addr_o), 0);
      checkOutput({name, "_a_valid"}, int'(a_valid_o), 0);
      checkOutput({name, "_b_valid"}, int'(b_valid_o), 0);
      checkOutput({name, "_init_save"}, int'(init_save_o), 0);
      checkOutput({name, "_acc_clr"}, int'(acc_clr_o), 0);
      checkOutput({name, "_c_valid"}, int'(c_valid_o), 0);
      checkOutput({name, "_c_addr"}, int'(c_addr_o), 0);
      checkOutput({name, "_busy"}, int'(busy_o), 0);
      checkOutput({name, "_done"}, int'(done_o), 0);
   endtask

   // Monitor: samples on the falling edge. Operand strobes are matched to the
   // address presented one cycle earlier (SRAM latency); c_addr must match the
   // queue head on every WRITE cycle (held during stalls) and the entry is
   // retired on the handshake cycle; done/acc_clr retire the done entry.
   initial begin
      int  prevA;
      int  prevB;
      bit  prevDone;
      op_t op;
      wr_t wr;
      int  dc;
      prevA = 0;
      prevB = 0;
      prevDone = 1'b0;
      forever begin
         @(negedge clk);
         if (a_valid_o === 1'b1 || b_valid_o === 1'b1 || init_save_o === 1'b1) begin
            if (opQ.size() == 0) begin
               checkOutput("unexpected_strobe", 1, 0);
            end else begin
               op = opQ.pop_front();
               checkOutput("op_cycle", cyc, op.cyc);
               checkOutput("a_addr", prevA, op.a);
               checkOutput("b_addr", prevB, op.b);
               checkOutput("a_valid", int'(a_valid_o), 1);
               checkOutput("b_valid", int'(b_valid_o), 1);
               checkOutput("init_save", int'(init_save_o), op.init);
            end
         end
         if (c_valid_o === 1'b1) begin
            if (cQ.size() == 0) begin
               checkOutput("unexpected_c_valid", 1, 0);
            end else begin
               checkOutput("c_addr", int'(c_addr_o), cQ[0].addr);
               if (c_ready_i === 1'b1) begin
                  wr = cQ.pop_front();
                  checkOutput("c_handshake_cycle", cyc, wr.cyc);
               end
            end
         end
         if (done_o === 1'b1 || acc_clr_o === 1'b1) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpected_done", 1, 0);
            end else begin
               dc = doneQ.pop_front();
               checkOutput("done_cycle", cyc, dc);
               checkOutput("done", int'(done_o), 1);
               checkOutput("acc_clr", int'(acc_clr_o), 1);
               checkOutput("busy_in_done", int'(busy_o), 1);
            end
         end
         if (prevDone) checkOutput("busy_after_done", int'(busy_o), 0);
         prevDone = (done_o === 1'b1);
         prevA = int'(a_addr_o);
         prevB = int'(b_addr_o);
      end
   end

   // Directed test sequence.
   initial begin
      rst_i    = 1'b1;
      start_i  = 1'b0;
      m_size_i = 8'd0;
      k_size_i = 8'd0;
      n_size_i = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      $display("[TB] basic 1x1x1 job");
      applyStimulus(1, 1, 1, 0, 1'b1);
      waitDone("basic");

      $display("[TB] 2x2x3 tile and address order");
      applyStimulus(2, 2, 3, 0, 1'b1);
      waitDone("order");

      $display("[TB] 2x2x3 with three stall cycles per write");
      applyStimulus(2, 2, 3, 3, 1'b1);
      waitDone("backpressure");

      $display("[TB] zero-size jobs");
      applyStimulus(2, 2, 0, 0, 1'b1);
      waitDone("zero_k");
      applyStimulus(0, 3, 2, 0, 1'b1);
      waitDone("zero_m");

      // Reset while tile 1 (m=0, n=1) is loading: only tile 0 and the first
      // operand pair of tile 1 may reach the PE before everything goes quiet.
      $display("[TB] reset mid-job");
      applyStimulus(2, 2, 3, 0, 1'b0);
      opQ.push_back('{startCyc + 2, 0, 0, 1});
      opQ.push_back('{startCyc + 3, 1, 2, 0});
      opQ.push_back('{startCyc + 4, 2, 4, 0});
      cQ.push_back('{startCyc + 5, 0});
      opQ.push_back('{startCyc + 7, 0, 1, 1});
      gotoCycle(startCyc + 7);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      checkAllZero("mid_reset");
      checkOutput("mid_reset_ops_left", opQ.size(), 0);
      checkOutput("mid_reset_writes_left", cQ.size(), 0);
      opQ.delete();
      cQ.delete();
      applyStimulus(1, 1, 1, 0, 1'b1);
      waitDone("after_reset");

      // Start pulses with other sizes during LOAD and WRITE of tile 0 must
      // leave the original 2x2x3 sequence untouched.
      $display("[TB] start while busy");
      applyStimulus(2, 2, 3, 0, 1'b1);
      gotoCycle(startCyc + 2);
      m_size_i = 8'd1;
      k_size_i = 8'd5;
      n_size_i = 8'd1;
      start_i  = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      gotoCycle(startCyc + 5);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      waitDone("start_busy");

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
